// File: rtl/rd_label_decode_pkg.sv
// Shared encodings for the label-tracking decode stage: MIPS opcode and
// function fields, the SETR label-set instruction, and the syscall FSM states.
package rd_label_decode_pkg;

  // Primary opcodes (I[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP1    = 6'h11;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LWC1    = 6'h31;
  localparam logic [5:0] OP_SWC1    = 6'h39;

  // SETR reuses the ADDI opcode with rs = rt = 0
  localparam logic [5:0]  OP_SETR    = OP_ADDI;
  localparam logic [15:0] SETR_MATCH = 16'h2000;
  localparam int          SETR_MODE_HI = 15;
  localparam int          SETR_MODE_LO = 14;

  // SPECIAL function codes (I[5:0])
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt codes (I[20:16])
  localparam logic [4:0] RI_BLTZ    = 5'h00;
  localparam logic [4:0] RI_BGEZ    = 5'h01;
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    LMODE_BOTH  = 2'b00,
    LMODE_READ  = 2'b01,
    LMODE_WRITE = 2'b10,
    LMODE_NONE  = 2'b11
  } label_mode_t;

  typedef enum logic {
    SYS_IDLE  = 1'b0,
    SYS_STALL = 1'b1
  } sys_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/rd_label_decode_if.sv
// Bundle of the decode stage's instruction inputs and decoded outputs.
// master = upstream/downstream pipeline side, slave = the decode stage.
interface rd_label_decode_if #(
  parameter int LABEL_W = 1
);
  logic [31:0]        I1;
  logic               I1Valid;
  logic [31:0]        I2;
  logic               I2Valid;
  logic               Stall;
  logic               Accept;
  logic [4:0]         RSaddr;
  logic [4:0]         RTaddr;
  logic [4:0]         RDaddr;
  logic [31:0]        Imm;
  logic               DecValid;
  logic               instIsSyscall;
  logic               IllegalInst;
  logic               IllegalSeen;
  logic               SyscallStall;
  logic [LABEL_W-1:0] ReadLabel;
  logic [LABEL_W-1:0] WriteLabel;

  modport master (
    output I1, I1Valid, I2, I2Valid, Stall,
    input  Accept, RSaddr, RTaddr, RDaddr, Imm, DecValid, instIsSyscall,
           IllegalInst, IllegalSeen, SyscallStall, ReadLabel, WriteLabel
  );

  modport slave (
    input  I1, I1Valid, I2, I2Valid, Stall,
    output Accept, RSaddr, RTaddr, RDaddr, Imm, DecValid, instIsSyscall,
           IllegalInst, IllegalSeen, SyscallStall, ReadLabel, WriteLabel
  );
endinterface

// File: rtl/rd_label_decode_decode.sv
// Purely combinational instruction classifier: destination register,
// immediate, legality and syscall detection for one 32-bit instruction.
module rd_decode_comb
  import rd_label_decode_pkg::*;
(
  input  logic [31:0] I1,
  output logic [4:0]  RD,
  output logic [31:0] Imm,
  output logic        instOK,
  output logic        isSyscall
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign op    = I1[31:26];
  assign rs    = I1[25:21];
  assign rt    = I1[20:16];
  assign rd    = I1[15:11];
  assign imm16 = I1[15:0];
  assign funct = I1[5:0];

  // Classify the opcode; anything not listed stays illegal with RD = 0, Imm = 0
  always_comb begin
    RD        = 5'd0;
    Imm       = 32'h0;
    instOK    = 1'b0;
    isSyscall = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
          FN_NOR, FN_SLT, FN_SLTU, FN_JALR, FN_MFHI, FN_MFLO: begin
            instOK = 1'b1;
            RD     = rd;
          end
          FN_JR, FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            instOK = 1'b1;
          end
          FN_SYSCALL: begin
            instOK    = 1'b1;
            isSyscall = 1'b1;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        instOK = (rt == RI_BLTZ) || (rt == RI_BGEZ) ||
                 (rt == RI_BLTZAL) || (rt == RI_BGEZAL);
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_COP1: begin
        instOK = 1'b1;
      end
      OP_JAL: begin
        instOK = 1'b1;
        RD     = REG_RA;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        instOK = 1'b1;
        RD     = rt;
        Imm    = sext16(imm16);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        instOK = 1'b1;
        RD     = rt;
        Imm    = zext16(imm16);
      end
      OP_LUI: begin
        instOK = 1'b1;
        RD     = rt;
        Imm    = {imm16, 16'h0000};
      end
      // LWC1 targets an FP register, so no integer destination
      OP_SB, OP_SH, OP_SW, OP_LWC1, OP_SWC1: begin
        instOK = 1'b1;
        Imm    = sext16(imm16);
      end
      default: ;
    endcase
    if (op == OP_SETR && rs == 5'd0 && rt == 5'd0) begin
      isSyscall = 1'b1;
    end
  end

endmodule

// File: rtl/rd_label_decode.sv
// Registered decode stage with syscall stall sequencing and security labels.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SYS_IDLE  | no syscall outstanding; I1 may be accepted
// SYS_STALL | counting down the post-syscall bubble; Accept forced low
module rd_label_decode
  import rd_label_decode_pkg::*;
#(
  parameter int LABEL_W       = 1,
  parameter int SYSCALL_STALL = 2
) (
  input  logic            CLK,
  input  logic            MRST,
  rd_label_decode_if.slave bus
);

  localparam logic [3:0] STALL_LOAD = 4'(SYSCALL_STALL);

  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_ok;
  logic        dec_sys;

  logic        accept;

  logic [4:0]  rs_q, rt_q, rd_q;
  logic [31:0] imm_q;
  logic        dec_valid_q, sys_q, ill_q, ill_seen_q;

  sys_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_q;

  logic               setr;
  label_mode_t        setr_mode;
  logic [LABEL_W-1:0] setr_val;
  logic [LABEL_W-1:0] rlabel_q, wlabel_q;

  rd_decode_comb u_decode (
    .I1        (bus.I1),
    .RD        (dec_rd),
    .Imm       (dec_imm),
    .instOK    (dec_ok),
    .isSyscall (dec_sys)
  );

  assign accept = bus.I1Valid & ~bus.Stall & ~stall_q;

  // Output register: load on accept, drop valid on a bubble, freeze on Stall
  always_ff @(posedge CLK) begin
    if (MRST) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      dec_valid_q <= 1'b0;
      sys_q       <= 1'b0;
      ill_q       <= 1'b0;
      ill_seen_q  <= 1'b0;
    end else if (accept) begin
      rs_q        <= bus.I1[25:21];
      rt_q        <= bus.I1[20:16];
      rd_q        <= dec_rd;
      imm_q       <= dec_imm;
      dec_valid_q <= 1'b1;
      sys_q       <= dec_sys;
      ill_q       <= ~dec_ok;
      ill_seen_q  <= ill_seen_q | ~dec_ok;
    end else if (!bus.Stall) begin
      dec_valid_q <= 1'b0;
    end
  end

  // Syscall FSM next state; the countdown ignores downstream Stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SYS_IDLE: begin
        if (accept && dec_sys) begin
          state_d = SYS_STALL;
          cnt_d   = STALL_LOAD;
        end
      end
      SYS_STALL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = SYS_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = SYS_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Syscall FSM state, counter and registered non-zero flag
  always_ff @(posedge CLK) begin
    if (MRST) begin
      state_q <= SYS_IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (cnt_d != 4'd0);
    end
  end

  assign setr      = bus.I2Valid && (bus.I2[31:16] == SETR_MATCH);
  assign setr_mode = label_mode_t'(bus.I2[SETR_MODE_HI:SETR_MODE_LO]);
  assign setr_val  = bus.I2[LABEL_W-1:0];

  // Label bits above LABEL_W in the SETR payload are don't-care
  logic unused_i2;
  assign unused_i2 = ^bus.I2[13:0];

  // Security labels follow stage-3 SETR regardless of any stall
  always_ff @(posedge CLK) begin
    if (MRST) begin
      rlabel_q <= '0;
      wlabel_q <= '0;
    end else if (setr) begin
      case (setr_mode)
        LMODE_BOTH: begin
          rlabel_q <= setr_val;
          wlabel_q <= setr_val;
        end
        LMODE_READ:  rlabel_q <= setr_val;
        LMODE_WRITE: wlabel_q <= setr_val;
        default: ;
      endcase
    end
  end

  assign bus.Accept        = accept;
  assign bus.RSaddr        = rs_q;
  assign bus.RTaddr        = rt_q;
  assign bus.RDaddr        = rd_q;
  assign bus.Imm           = imm_q;
  assign bus.DecValid      = dec_valid_q;
  assign bus.instIsSyscall = sys_q;
  assign bus.IllegalInst   = ill_q;
  assign bus.IllegalSeen   = ill_seen_q;
  assign bus.SyscallStall  = stall_q;
  assign bus.ReadLabel     = rlabel_q;
  assign bus.WriteLabel    = wlabel_q;

endmodule

// File: tb/tb_rd_label_decode.sv
// Directed bench for rd_label_decode: a vector table for single-cycle decode
// plus hand sequences for stall, syscall bubble, labels, illegal and reset.
module tb_rd_label_decode;

  localparam int LW = 4;
  localparam int SS = 2;

  logic CLK = 1'b0;
  logic MRST;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  rd_label_decode_if #(.LABEL_W(LW)) bus ();

  rd_label_decode #(.LABEL_W(LW), .SYSCALL_STALL(SS)) dut (
    .CLK  (CLK),
    .MRST (MRST),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] i1;
    logic        vld;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        dv;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts cycles with SyscallStall high (bounded), checking Accept stays low
  task automatic wait_stall(output int n);
    n = 0;
    while (bus.SyscallStall === 1'b1 && n < 20) begin
      #1;
      chk("accept_in_stall", 32'(bus.Accept), 32'd0);
      tick();
      n++;
    end
  endtask

  int ns;

  initial begin
    vt[0]  = '{32'h2065FFFC, 1'b1, 5'd3,  5'd5,  5'd5,  32'hFFFFFFFC, 1'b1}; // ADDI
    vt[1]  = '{32'h34028001, 1'b1, 5'd0,  5'd2,  5'd2,  32'h00008001, 1'b1}; // ORI
    vt[2]  = '{32'h3C071234, 1'b1, 5'd0,  5'd7,  5'd7,  32'h12340000, 1'b1}; // LUI
    vt[3]  = '{32'h00221821, 1'b1, 5'd1,  5'd2,  5'd3,  32'h00000000, 1'b1}; // ADDU
    vt[4]  = '{32'h8FA4FFF8, 1'b1, 5'd29, 5'd4,  5'd4,  32'hFFFFFFF8, 1'b1}; // LW
    vt[5]  = '{32'hAFA40010, 1'b1, 5'd29, 5'd4,  5'd0,  32'h00000010, 1'b1}; // SW
    vt[6]  = '{32'h0C000100, 1'b1, 5'd0,  5'd0,  5'd31, 32'h00000000, 1'b1}; // JAL
    vt[7]  = '{32'h10220004, 1'b1, 5'd1,  5'd2,  5'd0,  32'h00000000, 1'b1}; // BEQ
    vt[8]  = '{32'h04710008, 1'b1, 5'd3,  5'd17, 5'd0,  32'h00000000, 1'b1}; // BGEZAL
    vt[9]  = '{32'h3109FFFF, 1'b1, 5'd8,  5'd9,  5'd9,  32'h0000FFFF, 1'b1}; // ANDI
    vt[10] = '{32'hDEADBEEF, 1'b0, 5'd8,  5'd9,  5'd9,  32'h0000FFFF, 1'b0}; // bubble
    vt[11] = '{32'h00031100, 1'b1, 5'd0,  5'd3,  5'd2,  32'h00000000, 1'b1}; // SLL
    vt[12] = '{32'h24217FFF, 1'b1, 5'd1,  5'd1,  5'd1,  32'h00007FFF, 1'b1}; // ADDIU

    MRST = 1'b1;
    bus.I1 = 32'h0; bus.I1Valid = 1'b0;
    bus.I2 = 32'h0; bus.I2Valid = 1'b0;
    bus.Stall = 1'b0;
    tick();
    tick();
    MRST = 1'b0;

    // reset state
    chk("rst_dv",     32'(bus.DecValid),     32'd0);
    chk("rst_imm",    bus.Imm,               32'h0);
    chk("rst_rd",     32'(bus.RDaddr),       32'd0);
    chk("rst_sstall", 32'(bus.SyscallStall), 32'd0);
    chk("rst_rlabel", 32'(bus.ReadLabel),    32'd0);
    chk("rst_illseen",32'(bus.IllegalSeen),  32'd0);
    chk("rst_accept", 32'(bus.Accept),       32'd0);

    // table: single-cycle decode, no stall
    for (int k = 0; k < NV; k++) begin
      bus.I1 = vt[k].i1;
      bus.I1Valid = vt[k].vld;
      bus.Stall = 1'b0;
      #1;
      chk($sformatf("v%0d_accept", k), 32'(bus.Accept), 32'(vt[k].vld));
      tick();
      chk($sformatf("v%0d_rs", k),  32'(bus.RSaddr),        32'(vt[k].rs));
      chk($sformatf("v%0d_rt", k),  32'(bus.RTaddr),        32'(vt[k].rt));
      chk($sformatf("v%0d_rd", k),  32'(bus.RDaddr),        32'(vt[k].rd));
      chk($sformatf("v%0d_imm", k), bus.Imm,                vt[k].imm);
      chk($sformatf("v%0d_dv", k),  32'(bus.DecValid),      32'(vt[k].dv));
      chk($sformatf("v%0d_sys", k), 32'(bus.instIsSyscall), 32'd0);
      chk($sformatf("v%0d_ill", k), 32'(bus.IllegalInst),   32'd0);
    end

    // ORI held off by Stall for 3 cycles; previous ADDIU outputs must hold
    bus.I1 = 32'h34028001; bus.I1Valid = 1'b1; bus.Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_accept", 32'(bus.Accept), 32'd0);
      tick();
      chk("stall_imm_hold", bus.Imm, 32'h00007FFF);
      chk("stall_dv_hold",  32'(bus.DecValid), 32'd1);
    end
    bus.Stall = 1'b0;
    #1;
    chk("unstall_accept", 32'(bus.Accept), 32'd1);
    tick();
    chk("unstall_imm", bus.Imm, 32'h00008001);
    chk("unstall_rt",  32'(bus.RTaddr), 32'd2);
    bus.I1Valid = 1'b0;
    tick();
    chk("bubble_dv", 32'(bus.DecValid), 32'd0);

    // SPECIAL/SYSCALL, next instruction held valid upstream
    bus.I1 = 32'h0000000C; bus.I1Valid = 1'b1;
    #1;
    chk("sys_accept", 32'(bus.Accept), 32'd1);
    tick();
    chk("sys_flag", 32'(bus.instIsSyscall), 32'd1);
    chk("sys_dv",   32'(bus.DecValid), 32'd1);
    bus.I1 = 32'h2065FFFC;
    wait_stall(ns);
    chk("sys_stall_len", 32'(ns), 32'(SS));
    #1;
    chk("sys_reaccept", 32'(bus.Accept), 32'd1);
    tick();
    chk("post_sys_rs",  32'(bus.RSaddr), 32'd3);
    chk("post_sys_sys", 32'(bus.instIsSyscall), 32'd0);

    // SETR in stage 2 is also a syscall
    bus.I1 = 32'h20000001;
    tick();
    chk("setr1_sys", 32'(bus.instIsSyscall), 32'd1);
    chk("setr1_imm", bus.Imm, 32'h00000001);
    bus.I1Valid = 1'b0;
    wait_stall(ns);
    chk("setr1_stall_len", 32'(ns), 32'(SS));

    // label updates from stage 3
    bus.I2Valid = 1'b1; bus.I2 = 32'h20000001;
    tick();
    chk("lbl_both1_r", 32'(bus.ReadLabel), 32'd1);
    chk("lbl_both1_w", 32'(bus.WriteLabel), 32'd1);
    bus.I2 = 32'h20004000;
    tick();
    chk("lbl_rd0_r", 32'(bus.ReadLabel), 32'd0);
    chk("lbl_rd0_w", 32'(bus.WriteLabel), 32'd1);
    bus.I2 = 32'h20008005;
    tick();
    chk("lbl_wr5_w", 32'(bus.WriteLabel), 32'd5);
    bus.I2 = 32'h2000C00F;
    tick();
    chk("lbl_nop_r", 32'(bus.ReadLabel), 32'd0);
    chk("lbl_nop_w", 32'(bus.WriteLabel), 32'd5);
    bus.I2Valid = 1'b0; bus.I2 = 32'h20000007;
    tick();
    chk("lbl_invalid_w", 32'(bus.WriteLabel), 32'd5);
    bus.I2Valid = 1'b1; bus.I2 = 32'h20000003;
    tick();
    bus.I2 = 32'h20004006;
    tick();
    chk("lbl_b2b_r", 32'(bus.ReadLabel), 32'd6);
    chk("lbl_b2b_w", 32'(bus.WriteLabel), 32'd3);
    bus.Stall = 1'b1; bus.I2 = 32'h20008009;
    tick();
    chk("lbl_stall_w", 32'(bus.WriteLabel), 32'd9);
    bus.Stall = 1'b0; bus.I2Valid = 1'b0;

    // illegal instructions: flag, RD forced to 0, sticky seen bit
    chk("ill_seen_pre", 32'(bus.IllegalSeen), 32'd0);
    bus.I1 = 32'hFC000000; bus.I1Valid = 1'b1;
    #1;
    chk("ill_accept", 32'(bus.Accept), 32'd1);
    tick();
    chk("ill_flag", 32'(bus.IllegalInst), 32'd1);
    chk("ill_rd",   32'(bus.RDaddr), 32'd0);
    chk("ill_imm",  bus.Imm, 32'h0);
    chk("ill_seen", 32'(bus.IllegalSeen), 32'd1);
    chk("ill_dv",   32'(bus.DecValid), 32'd1);
    bus.I1 = 32'h2065FFFC;
    tick();
    chk("ill_clear",  32'(bus.IllegalInst), 32'd0);
    chk("ill_sticky", 32'(bus.IllegalSeen), 32'd1);
    bus.I1 = 32'h04420000;
    tick();
    chk("ill_regimm", 32'(bus.IllegalInst), 32'd1);

    // reset during the syscall bubble with labels non-zero
    bus.I1 = 32'h0000000C;
    tick();
    chk("rst2_in_stall", 32'(bus.SyscallStall), 32'd1);
    MRST = 1'b1; bus.I1 = 32'h2065FFFC;
    tick();
    MRST = 1'b0;
    chk("rst2_sstall",  32'(bus.SyscallStall),  32'd0);
    chk("rst2_dv",      32'(bus.DecValid),      32'd0);
    chk("rst2_sys",     32'(bus.instIsSyscall), 32'd0);
    chk("rst2_ill",     32'(bus.IllegalInst),   32'd0);
    chk("rst2_illseen", 32'(bus.IllegalSeen),   32'd0);
    chk("rst2_rs",      32'(bus.RSaddr),        32'd0);
    chk("rst2_imm",     bus.Imm,                32'h0);
    chk("rst2_rlabel",  32'(bus.ReadLabel),     32'd0);
    chk("rst2_wlabel",  32'(bus.WriteLabel),    32'd0);
    #1;
    chk("rst2_accept", 32'(bus.Accept), 32'd1);
    tick();
    chk("rst2_after_dv", 32'(bus.DecValid), 32'd1);
    chk("rst2_after_rs", 32'(bus.RSaddr), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rd_label_decode.md
# rd_label_decode

Parametrised, registered successor to the minicpu decode stage. It decodes the stage-2 instruction into register specifiers, a 32-bit immediate, and syscall and illegal-instruction flags, and holds them in a stallable output register. It also runs the syscall stall counter and maintains multi-bit read/write security labels, updated by SETR instructions seen in stage 3. Illegal instructions raise a flag and do not stop simulation.

## Interface
- LABEL_W, 1: width of ReadLabel/WriteLabel; legal range 1..14.
- SYSCALL_STALL, 2: stall cycles inserted after an accepted syscall; legal range 1..15.
- CLK  in  1  clock, rising edge.
- MRST  in  1  reset; synchronous and active-high.
- I1  in  32  stage-2 instruction.
- I1Valid  in  1  I1 holds a real instruction.
- I2  in  32  stage-3 instruction.
- I2Valid  in  1  I2 holds a real instruction.
- Stall  in  1  downstream hazard stall; freezes the output register.
- Accept  out  1  combinational: I1 is consumed this cycle.
- RSaddr, RTaddr, RDaddr  out  5 each  registered register specifiers.
- Imm  out  32  registered immediate.
- DecValid  out  1  registered; the output register holds a decoded instruction.
- instIsSyscall  out  1  registered; the held instruction is a syscall or SETR.
- IllegalInst  out  1  registered; the held instruction is illegal.
- IllegalSeen  out  1  sticky OR of every accepted IllegalInst.
- SyscallStall  out  1  registered; the syscall stall counter is non-zero.
- ReadLabel, WriteLabel  out  LABEL_W each  current security labels.

## Operation
- Accept = I1Valid & ~Stall & ~SyscallStall.
- Decode rules:
  - RS = I1[rs], RT = I1[rt].
  - RD = rt for loads and immediate ALU ops (ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI).
  - RD = rd for SPECIAL ALU, shift, JALR, MFHI and MFLO.
  - RD = 31 for JAL; 0 otherwise.
- Imm rules:
  - Sign-extend for loads, stores, ADDI, ADDIU, SLTI and SLTIU.
  - Zero-extend for ANDI, ORI and XORI.
  - LUI gives {imm,16'b0}.
  - Otherwise Imm = 32'h0; never X.
- Legal set: the current minicpu list, including REGIMM BLTZ/BGEZ/BGEZAL/BLTZAL, LWC1, SWC1 and COP1. Any other instruction sets IllegalInst; decode proceeds with RD = 0.
- Syscall: SPECIAL/SYSCALL, or op SETR with rs=rt=0.
- Output register update:
  - If Accept: load all decoded fields; DecValid=1.
  - Else if ~Stall: DecValid=0; fields hold.
  - Else (Stall): everything holds.
- Syscall FSM, states IDLE and STALL, with a 4-bit counter:
  - IDLE→STALL when Accept and the instruction is a syscall; counter=SYSCALL_STALL.
  - In STALL, decrement each cycle; →IDLE when the counter reaches 0.
  - Stall does not pause the counter.
- SETR recognition: I2Valid & I2[31:16]==16'h2000. Mode is I2[15:14]; value v = I2[LABEL_W-1:0].
  - Mode 00: both labels = v.
  - Mode 01: ReadLabel = v.
  - Mode 10: WriteLabel = v.
  - Mode 11: no change.
  - 32'h20000000 and 32'h20000001 therefore set both labels to 0 and 1.
- Label updates are independent of Stall and SyscallStall.

## Timing
- Reset: MRST at a clock edge sets the following to 0 and overrides every other update in that cycle:
  - RSaddr, RTaddr, RDaddr, Imm.
  - DecValid, instIsSyscall, IllegalInst, IllegalSeen.
  - SyscallStall, counter and FSM (FSM to IDLE).
  - ReadLabel, WriteLabel.
- Decode latency: 1 cycle from Accept to DecValid.
- Syscall accepted at edge n: SyscallStall is high for edges n+1 .. n+SYSCALL_STALL; Accept can next be high in the following cycle.
- Label update: visible 1 cycle after the SETR cycle in I2.
- Back-to-back SETRs apply in order; the last one wins per label.
- Reset asserted mid-stall: the stall aborts and Accept is available on the first cycle after MRST falls.
- A syscall cannot be re-accepted while SyscallStall is high; upstream holds I1.

## Structure
- Extend mips.h:
  - SETR opcode, SETR_MODE field [15:14], label mode codes.
  - Existing op/function/rt field macros, `dc5, `dc6.
- One combinational sub-module, rd_decode_comb. Input I1; outputs RD, Imm, instOK, isSyscall.
- The top module holds the output register, the syscall FSM/counter and the label registers.

## Test plan
- ADDI r5,r3,-4 (32'h2065FFFC), no stall → next cycle RS=3, RT=5, RD=5, Imm=32'hFFFFFFFC, DecValid=1.
- ORI r2,r0,0x8001, with Stall high for 3 cycles → Accept=0 and outputs held; after release Imm=32'h00008001.
- SPECIAL/SYSCALL with SYSCALL_STALL=2 → instIsSyscall=1; SyscallStall high exactly 2 cycles; Accept=0 meanwhile.
- I2=32'h20000001 → both labels 1 next cycle. I2=32'h20004000 (mode 01, v=0) with LABEL_W=4 → ReadLabel=0, WriteLabel stays 1.
- I1=32'hFC000000 (undefined op) → IllegalInst=1, RD=0, IllegalSeen sticks; simulation continues.
- MRST asserted during STALL with labels nonzero → all outputs 0 next cycle and Accept available immediately after.
